// File: rtl/seq_divider_pkg.sv
// Shared definitions for the multicycle signed divider: FSM state encoding and default width.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_RUN  = 2'b01,
        DIV_FIX  = 2'b10
    } div_state_t;

    localparam int DIV_WIDTH = 32;

endpackage

// File: rtl/seq_divider_step.sv
// One restoring shift-and-subtract iteration on unsigned magnitudes (purely combinational).
module seq_divider_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] p_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] p_shift;
    logic [WIDTH:0] sub_b;
    logic [WIDTH:0] diff;
    logic           carry;
    logic           nonneg;

    assign p_shift = {p, q[WIDTH-1]};
    assign sub_b   = ~{1'b0, divisor};

    // Ripple-carry subtract: p_shift + ~divisor + 1, one extra bit so the sign is visible
    always_comb begin
        carry = 1'b1;
        diff  = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            diff[i] = p_shift[i] ^ sub_b[i] ^ carry;
            carry   = (p_shift[i] & sub_b[i]) | (carry & (p_shift[i] ^ sub_b[i]));
        end
    end

    assign nonneg = ~diff[WIDTH];
    assign p_next = nonneg ? diff[WIDTH-1:0] : p_shift[WIDTH-1:0];
    assign q_next = {q[WIDTH-2:0], nonneg};

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed divider: magnitudes are divided one bit per cycle, signs restored at the end.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             result_rdy,
    output logic             exception,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic             neg);
        return neg ? ((~mag) + {{(WIDTH-1){1'b0}}, 1'b1}) : mag;
    endfunction

    // The most negative value maps to the unsigned 2^(WIDTH-1), so no overflow here
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return apply_sign($unsigned(v), v[WIDTH-1]);
    endfunction

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    div_state_t              state;
    div_state_t              state_next;
    logic [CNT_W-1:0]        count;
    logic [WIDTH-1:0]        p_r;
    logic [WIDTH-1:0]        q_r;
    logic [WIDTH-1:0]        b_mag;
    logic                    sign_q;
    logic                    sign_r;
    logic [WIDTH-1:0]        p_next;
    logic [WIDTH-1:0]        q_next;
    logic                    div_zero;
    logic [WIDTH-1:0]        fix_quot_p1;
    logic [WIDTH-1:0]        fix_rem_p1;
    logic                    fix_exc_p1;
    logic                    vld_p1;

    assign a_s      = operand_a;
    assign b_s      = operand_b;
    assign div_zero = (b_mag == '0);

    seq_divider_step #(.WIDTH(WIDTH)) u_step (
        .p       (p_r),
        .q       (q_r),
        .divisor (b_mag),
        .p_next  (p_next),
        .q_next  (q_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new start always wins, which gives both abort-and-restart and start-during-FIX
    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: if (ctrl_div) state_next = DIV_RUN;
            DIV_RUN: begin
                if (ctrl_div) begin
                    state_next = DIV_RUN;
                end else if (count == CNT_LAST) begin
                    state_next = DIV_FIX;
                end
            end
            DIV_FIX:  state_next = ctrl_div ? DIV_RUN : DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= (state == DIV_FIX);
            if (ctrl_div) begin
                count <= '0;
            end else if (state == DIV_RUN) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // Stage 0: operand load and iteration
    always_ff @(posedge clock) begin
        if (ctrl_div) begin
            p_r    <= '0;
            q_r    <= magnitude(a_s);
            b_mag  <= magnitude(b_s);
            sign_q <= a_s[WIDTH-1] ^ b_s[WIDTH-1];
            sign_r <= a_s[WIDTH-1];
        end else if (state == DIV_RUN) begin
            p_r <= p_next;
            q_r <= q_next;
        end
    end

    // Stage 1: sign restoration and divide-by-zero override
    always_ff @(posedge clock) begin
        if (state == DIV_FIX) begin
            fix_quot_p1 <= div_zero ? '0 : apply_sign(q_r, sign_q);
            fix_rem_p1  <= div_zero ? '0 : apply_sign(p_r, sign_r);
            fix_exc_p1  <= div_zero;
        end
    end

    // Stage 2: architectural outputs, held until the next result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            quotient   <= '0;
            remainder  <= '0;
            exception  <= 1'b0;
            result_rdy <= 1'b0;
        end else begin
            result_rdy <= vld_p1;
            if (vld_p1) begin
                quotient  <= fix_quot_p1;
                remainder <= fix_rem_p1;
                exception <= fix_exc_p1;
            end else if (ctrl_div) begin
                exception <= 1'b0;
            end
        end
    end

    assign busy = (state != DIV_IDLE) | vld_p1;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=32): directed operands with hand-computed results.
module tb_seq_divider;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
        int          cyc;
        string       nm;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_div = 1'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        result_rdy;
    logic        exception;
    logic        busy;

    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   rdy_seen = 0;
    exp_t exp_q[$];

    seq_divider #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .ctrl_div   (ctrl_div),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .quotient   (quotient),
        .remainder  (remainder),
        .result_rdy (result_rdy),
        .exception  (exception),
        .busy       (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per result_rdy pulse
    always @(negedge clock) begin
        exp_t e;
        if (result_rdy === 1'b1) begin
            rdy_seen++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_rdy: result_rdy=1 at cycle %0d with q=0x%08h, expected no result", cyc, quotient);
            end else begin
                e = exp_q.pop_front();
                check32({e.nm, ".quotient"},  quotient,       e.q);
                check32({e.nm, ".remainder"}, remainder,      e.r);
                check32({e.nm, ".exception"}, {31'd0, exception}, {31'd0, e.exc});
                check32({e.nm, ".latency"},   cyc,            e.cyc);
            end
        end
    end

    // Result appears 34 edges after the sampling edge, i.e. at cyc = now + 35 on that negedge
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input logic ex, input string nm, input bit abort_prev);
        exp_t e;
        @(negedge clock);
        operand_a = a;
        operand_b = b;
        ctrl_div  = 1'b1;
        if (abort_prev && exp_q.size() != 0) void'(exp_q.pop_back());
        e.q = eq; e.r = er; e.exc = ex; e.cyc = cyc + 35; e.nm = nm;
        exp_q.push_back(e);
        @(posedge clock);
        #1 ctrl_div = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s.timeout: %0d results outstanding, expected 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int busy_cnt;
        int rdy_snap;

        repeat (3) @(negedge clock);
        check32("reset.quotient",   quotient,  32'd0);
        check32("reset.remainder",  remainder, 32'd0);
        check32("reset.result_rdy", {31'd0, result_rdy}, 32'd0);
        check32("reset.exception",  {31'd0, exception},  32'd0);
        check32("reset.busy",       {31'd0, busy},       32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "pos_pos", 1'b0);
        @(negedge clock);
        busy_cnt = 0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clock);
            if (busy === 1'b1) busy_cnt++;
        end
        check32("pos_pos.busy_cycles", busy_cnt, 32'd33);
        @(negedge clock);
        check32("pos_pos.busy_drop", {31'd0, busy}, 32'd0);
        check32("pos_pos.rdy_at_34", {31'd0, result_rdy}, 32'd1);
        wait_drain("pos_pos");

        issue(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, "neg_pos", 1'b0);
        wait_drain("neg_pos");
        issue(32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, "pos_neg", 1'b0);
        wait_drain("pos_neg");
        issue(32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, "neg_neg", 1'b0);
        wait_drain("neg_neg");

        issue(32'd5, 32'd0, 32'd0, 32'd0, 1'b1, "div_zero", 1'b0);
        wait_drain("div_zero");
        @(negedge clock);
        check32("div_zero.exc_hold", {31'd0, exception}, 32'd1);
        issue(32'd6, 32'd3, 32'd2, 32'd0, 1'b0, "after_zero", 1'b0);
        @(negedge clock);
        check32("after_zero.exc_clear", {31'd0, exception}, 32'd0);
        wait_drain("after_zero");

        issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, "min_by_m1", 1'b0);
        wait_drain("min_by_m1");
        issue(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, "min_by_1", 1'b0);
        wait_drain("min_by_1");
        issue(32'd7, 32'd100, 32'd0, 32'd7, 1'b0, "small_pos", 1'b0);
        wait_drain("small_pos");
        issue(32'hFFFF_FFF9, 32'd100, 32'd0, 32'hFFFF_FFF9, 1'b0, "small_neg", 1'b0);
        wait_drain("small_neg");

        rdy_snap = rdy_seen;
        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "aborted", 1'b0);
        repeat (9) @(negedge clock);
        issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, "restart", 1'b1);
        wait_drain("restart");
        repeat (3) @(negedge clock);
        check32("restart.rdy_count", rdy_seen - rdy_snap, 32'd1);

        rdy_snap = rdy_seen;
        issue(32'd20, 32'd6, 32'd3, 32'd2, 1'b0, "fix_old", 1'b0);
        repeat (32) @(negedge clock);
        issue(32'd50, 32'd7, 32'd7, 32'd1, 1'b0, "fix_new", 1'b0);
        wait_drain("fix_new");
        repeat (3) @(negedge clock);
        check32("fix.rdy_count", rdy_seen - rdy_snap, 32'd2);

        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "reset_mid", 1'b0);
        void'(exp_q.pop_back());
        repeat (14) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check32("reset_mid.busy",       {31'd0, busy},       32'd0);
        check32("reset_mid.quotient",   quotient,            32'd0);
        check32("reset_mid.remainder",  remainder,           32'd0);
        check32("reset_mid.result_rdy", {31'd0, result_rdy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        rdy_snap = rdy_seen;
        repeat (40) @(negedge clock);
        check32("reset_mid.no_rdy", rdy_seen - rdy_snap, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
